// File: rtl/shift194_seq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : shift194_seq_ctrl_pkg
// Description : Shared constants for the 74HC194 running-light sequencer.
//               Register mode codes, sequencer state encoding and the
//               number of shift steps per rotate phase.
// Revision    : 1.0 - initial release
// ============================================================================
package shift194_seq_ctrl_pkg;

    // 74HC194 mode select S[1:0]
    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_SR   = 2'b01;
    localparam logic [1:0] MODE_SL   = 2'b10;
    localparam logic [1:0] MODE_LOAD = 2'b11;

    // Sequencer states
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_LOAD  = 2'd1;
    localparam logic [1:0] ST_RIGHT = 2'd2;
    localparam logic [1:0] ST_LEFT  = 2'd3;

    // Shift pulses per phase: a full turn of the 4-bit register
    localparam int STEPS  = 4;
    localparam int STEP_W = $clog2(STEPS);

endpackage
`default_nettype wire

// File: rtl/shift194_step_tick.sv
`default_nettype none
// ============================================================================
// Module      : shift194_step_tick
// Description : Step-rate prescaler. Counts pc = 0..div and flags the
//               compare cycle; pc returns to 0 on the compare cycle.
// Ports       : Clk  - system clock
//               MR   - synchronous active-high reset
//               clr  - synchronous counter clear (phase restart / idle)
//               div  - step period minus 1, in Clk cycles
//               tick - high while pc == div (combinational from pc)
// Revision    : 1.0 - initial release
// ============================================================================
module shift194_step_tick #(
    parameter int DIV_W = 4
) (
    input  logic             Clk,
    input  logic             MR,
    input  logic             clr,
    input  logic [DIV_W-1:0] div,
    output logic             tick
);

    logic [DIV_W-1:0] r_pc;

    // Equality compare against the live div value: if div is lowered below
    // pc, pc keeps counting and wraps through all-ones back to 0.
    assign tick = (r_pc == div);

    always_ff @(posedge Clk) begin
        if (MR || clr) begin
            r_pc <= '0;
        end else if (tick) begin
            r_pc <= '0;
        end else begin
            r_pc <= r_pc + DIV_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/shift194_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : shift194_seq_ctrl
// Description : Upstream sequencer for a 74HC194-style 4-bit universal shift
//               register. Loads a seed, rotates it right 4 steps, left 4
//               steps, and repeats until stopped. A shadow copy of the
//               register supplies the rotate feedback and the expected Q.
// Ports       : Clk     - system clock
//               MR      - synchronous active-high reset
//               start   - begin a sequence (sampled in IDLE only)
//               stop    - request end of sequence (latched while busy)
//               pattern - seed [0:3]
//               div     - step period minus 1
//               S       - register mode select
//               Dsr/Dsl - serial inputs for right/left shift
//               D       - parallel load data [0:3]
//               exp_q   - shadow register contents [0:3]
//               busy    - sequence in progress
//               done    - one-cycle end-of-sequence pulse
// Revision    : 1.0 - initial release
// ============================================================================
module shift194_seq_ctrl
    import shift194_seq_ctrl_pkg::*;
#(
    parameter int DIV_W = 4
) (
    input  logic             Clk,
    input  logic             MR,
    input  logic             start,
    input  logic             stop,
    input  logic [0:3]       pattern,
    input  logic [DIV_W-1:0] div,
    output logic [1:0]       S,
    output logic             Dsr,
    output logic             Dsl,
    output logic [0:3]       D,
    output logic [0:3]       exp_q,
    output logic             busy,
    output logic             done
);

    localparam logic [STEP_W-1:0] c_last_step = STEP_W'(STEPS - 1);

    logic [1:0]        r_state;
    logic [1:0]        r_s;
    logic              r_dsr;
    logic              r_dsl;
    logic [0:3]        r_d;
    logic [0:3]        r_exp_q;
    logic              r_busy;
    logic              r_done;
    logic              r_stop_req;
    logic [STEP_W-1:0] r_step;

    logic              w_tick;
    logic              w_clr;
    logic              w_pulse_now;
    logic              w_phase_end;
    logic [0:3]        w_exp_next;

    // The current cycle carries a shift pulse of the active phase
    assign w_pulse_now = ((r_state == ST_RIGHT) && (r_s == MODE_SR)) ||
                         ((r_state == ST_LEFT)  && (r_s == MODE_SL));
    assign w_phase_end = w_pulse_now && (r_step == c_last_step);

    // Prescaler restarts from 0 at the start of every phase
    assign w_clr = (r_state == ST_IDLE) || (r_state == ST_LOAD) || w_phase_end;

    shift194_step_tick #(
        .DIV_W (DIV_W)
    ) u_step_tick (
        .Clk  (Clk),
        .MR   (MR),
        .clr  (w_clr),
        .div  (div),
        .tick (w_tick)
    );

    // Register contents after this edge, from the mode driven this cycle
    always_comb begin
        w_exp_next = r_exp_q;
        case (r_s)
            MODE_LOAD: w_exp_next = r_d;
            MODE_SR:   w_exp_next = {r_dsr, r_exp_q[0:2]};
            MODE_SL:   w_exp_next = {r_exp_q[1:3], r_dsl};
            default:   w_exp_next = r_exp_q;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (MR) begin
            r_state    <= ST_IDLE;
            r_s        <= MODE_HOLD;
            r_dsr      <= 1'b0;
            r_dsl      <= 1'b0;
            r_d        <= '0;
            r_exp_q    <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_stop_req <= 1'b0;
            r_step     <= '0;
        end else begin
            r_exp_q <= w_exp_next;
            r_done  <= 1'b0;
            r_dsr   <= 1'b0;
            r_dsl   <= 1'b0;

            if ((r_state != ST_IDLE) && stop) begin
                r_stop_req <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    r_s <= MODE_HOLD;
                    if (start) begin
                        r_state    <= ST_LOAD;
                        r_s        <= MODE_LOAD;
                        r_d        <= pattern;
                        r_step     <= '0;
                        r_stop_req <= 1'b0;
                        r_busy     <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    r_state <= ST_RIGHT;
                    r_s     <= MODE_HOLD;
                end

                ST_RIGHT, ST_LEFT: begin
                    if (w_phase_end) begin
                        r_step <= '0;
                        r_s    <= MODE_HOLD;
                        if (r_state == ST_RIGHT) begin
                            r_state <= ST_LEFT;
                        end else if (r_stop_req) begin
                            r_state <= ST_IDLE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_RIGHT;
                        end
                    end else begin
                        if (w_pulse_now) begin
                            r_step <= r_step + STEP_W'(1);
                        end
                        if (w_tick) begin
                            // Feedback is taken from the contents the
                            // register will hold during the pulse cycle.
                            if (r_state == ST_RIGHT) begin
                                r_s   <= MODE_SR;
                                r_dsr <= w_exp_next[3];
                            end else begin
                                r_s   <= MODE_SL;
                                r_dsl <= w_exp_next[0];
                            end
                        end else begin
                            r_s <= MODE_HOLD;
                        end
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_s     <= MODE_HOLD;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign S     = r_s;
    assign Dsr   = r_dsr;
    assign Dsl   = r_dsl;
    assign D     = r_d;
    assign exp_q = r_exp_q;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
`default_nettype wire

// File: doc/shift194_seq_ctrl.md
Name: shift194_seq_ctrl

Overview:
- Upstream sequencer for the 4-bit universal shift register (74HC194-style: MR, S[1:0], Dsr, Dsl, D[0:3]).
- Generates the mode, serial-in and parallel-load stimulus that turns the register into a bidirectional running-light rotator: load seed, rotate right 4 steps, rotate left 4 steps, repeat until stopped.
- Keeps a shadow model of the register contents. This drives the rotate feedback bits and exports the expected Q for checking.

Parameters:
- DIV_W, 4, width of the step-rate divisor input `div`.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- MR  in  1  reset. Synchronous, active-high.
- start  in  1  begin a sequence; sampled only in IDLE.
- stop  in  1  request end of sequence; latched while busy.
- pattern  in  4  seed value, indexed [0:3], loaded into the register.
- div  in  DIV_W  step period minus 1, in Clk cycles.
- S  out  2  register mode: 00 hold, 01 shift right, 10 shift left, 11 load.
- Dsr  out  1  serial input for shift right.
- Dsl  out  1  serial input for shift left.
- D  out  4  [0:3] parallel load data.
- exp_q  out  4  [0:3] shadow of the register contents.
- busy  out  1  high whenever state != IDLE.
- done  out  1  one-cycle pulse at sequence end.

Behaviour:
- All outputs are registered.
- Reset values (MR=1 at an edge): state=IDLE, S=00, Dsr=0, Dsl=0, D=0000, exp_q=0000, busy=0, done=0, stop_req=0, pc=0, step=0.
- MR has priority over every other input, including mid-sequence.
- Shadow update, applied at each edge from the S value driven in that cycle, so it models the downstream register exactly:
  - 11: exp_q <= D.
  - 01: exp_q[0] <= Dsr, exp_q[i] <= exp_q[i-1].
  - 10: exp_q[3] <= Dsl, exp_q[i] <= exp_q[i+1].
  - 00: hold.
- State IDLE:
  - S=00.
  - If start=1: go to LOAD. In the same edge, drive S=11 and D=pattern, clear pc, step and stop_req.
- State LOAD (exactly 1 cycle):
  - S=11 is visible for this one cycle.
  - Next state is RIGHT, with S=00.
- State RIGHT / LEFT (prescaler behaviour):
  - Prescaler pc counts 0..div.
  - When pc==div: pc<=0, and for the following single cycle drive the shift mode (01 in RIGHT, 10 in LEFT) with the feedback bit.
    - RIGHT: Dsr = exp_q[3] (rotate right).
    - LEFT: Dsl = exp_q[0] (rotate left).
  - Otherwise pc<=pc+1 and S=00.
  - Result: one shift pulse every div+1 cycles. With div=0, S is held continuously at 01 (or 10).
- State RIGHT / LEFT (step counting):
  - step counts the shift pulses issued in the current phase.
  - After the 4th pulse cycle in RIGHT: go to LEFT, step=0, pc=0.
  - After the 4th pulse cycle in LEFT:
    - If stop_req=1: go to IDLE with done=1 for one cycle.
    - Else: go to RIGHT, step=0, pc=0.
- stop handling:
  - stop=1 in any non-IDLE cycle sets stop_req.
  - The sequence always finishes the current LEFT phase, so the register ends at the loaded seed.
  - stop in IDLE is ignored.
- start while busy: ignored.
- div changes mid-phase take effect at the next pc compare. If pc > div after a change, pc continues and wraps through 2^DIV_W-1 to 0.
- Dsr and Dsl are 0 in every cycle where the corresponding shift mode is not driven.
- D is held at the last loaded value.

Decomposition:
- Shared package contains:
  - mode constants MODE_HOLD=2'b00, MODE_SR=2'b01, MODE_SL=2'b10, MODE_LOAD=2'b11;
  - state encoding IDLE/LOAD/RIGHT/LEFT;
  - STEPS=4.
- One natural sub-module: shift194_step_tick, the divisor prescaler (Clk, MR, clr, div -> tick).

Test Plan:
- Reset: drive MR=1 for 2 cycles mid-RIGHT phase -> next cycle all outputs 0, state IDLE, busy=0.
- Rotate sequence with div=0, pattern=1000, start pulse -> LOAD cycle S=11, D=1000.
  - Right phase: S=01 for 4 cycles, exp_q 1000->0100->0010->0001->1000.
  - Left phase: S=10 for 4 cycles, exp_q 1000->0001->0010->0100->1000.
- Prescaler with div=2 -> S=01 pulses exactly every 3 cycles, each 1 cycle wide, S=00 between.
- Stop request: pattern=1100, assert stop during the 2nd RIGHT step -> phase continues through LEFT. done=1 for one cycle with exp_q=1100, then busy=0, S=00.
- start asserted while busy -> no LOAD, sequence timing unchanged.
- Co-simulation with the shift register instance (same Clk, its active-low MR tied inactive) -> register Q equals exp_q every cycle for 3 full rotate periods.
